// File: rtl/lut_mult_sched_ctrl.sv
// Burst sequencer for the pipelined quarter-square LUT multiplier: pops operand pairs,
// tags each issue through the multiplier latency and pushes products under output-FIFO credit.
module lut_mult_sched_ctrl #(
    parameter int DW  = 8,
    parameter int LAT = 4,
    parameter int CW  = 8,
    parameter int RW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CW-1:0]   op_count,
    output logic            busy,
    output logic            done,
    input  logic            in_empty,
    output logic            in_rd_en,
    input  logic [2*DW-1:0] in_data,
    output logic [DW-1:0]   mul_a,
    output logic [DW-1:0]   mul_b,
    output logic            mul_valid,
    input  logic [2*DW-1:0] mul_prod,
    input  logic [RW-1:0]   out_room,
    output logic            out_wr_en,
    output logic [2*DW-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  issued_q;
    logic [CW-1:0]  retired_q;
    logic [RW-1:0]  inflight_q;
    logic           busy_q;
    logic           done_q;
    logic           mul_valid_q;
    logic [LAT-1:0] vld_sr_q;

    logic           issue_ok;
    logic           push;
    logic           last_pop;
    logic           last_push;

    // The pop is decided from registered state plus the live FIFO flags, so both
    // in_empty and out_room already account for every earlier pop and push; this
    // keeps single-entry FIFOs safe while still issuing one op per cycle.
    always_comb begin
        issue_ok  = (state_q == ST_RUN) && !in_empty
                    && (issued_q < count_q) && (inflight_q < out_room);
        push      = vld_sr_q[LAT-1];
        last_pop  = issue_ok && (issued_q == count_q - CW'(1));
        last_push = push && (retired_q == count_q - CW'(1));
    end

    assign in_rd_en  = issue_ok;
    assign mul_a     = in_data[2*DW-1:DW];
    assign mul_b     = in_data[DW-1:0];
    assign mul_valid = mul_valid_q;
    assign out_wr_en = push;
    assign out_data  = mul_prod;
    assign busy      = busy_q;
    assign done      = done_q;

    // NOTE: every register here uses <= so all of them sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        count_q   <= op_count;
                        issued_q  <= '0;
                        retired_q <= '0;
                        if (op_count != '0) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (last_pop) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (last_push) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (issue_ok) issued_q  <= issued_q + CW'(1);
            if (push)     retired_q <= retired_q + CW'(1);

            case ({issue_ok, push})
                2'b10:   inflight_q <= inflight_q + RW'(1);
                2'b01:   inflight_q <= inflight_q - RW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Valid tag travels alongside the operands; its tail marks the product on mul_prod.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_q <= 1'b0;
            vld_sr_q    <= '0;
        end else begin
            mul_valid_q <= issue_ok;
            vld_sr_q    <= (vld_sr_q << 1) | LAT'(mul_valid_q);
        end
    end

    a_issue_bound:  assert property (@(posedge clk) disable iff (!rst_n) issued_q <= count_q);
    a_retire_bound: assert property (@(posedge clk) disable iff (!rst_n) retired_q <= issued_q);
    a_credit:       assert property (@(posedge clk) disable iff (!rst_n) inflight_q <= out_room);

endmodule

// File: tb/tb_lut_mult_sched_ctrl.sv
// Directed bench for lut_mult_sched_ctrl with an input FIFO model, a LAT-deep multiplier
// model and a product scoreboard fed from a hand-computed operand table.
module tb_lut_mult_sched_ctrl;

    localparam int DW  = 8;
    localparam int LAT = 4;
    localparam int CW  = 8;
    localparam int RW  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   op_count = '0;
    logic            busy;
    logic            done;
    logic            in_empty;
    logic            in_rd_en;
    logic [2*DW-1:0] in_data;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic            mul_valid;
    logic [2*DW-1:0] mul_prod;
    logic [RW-1:0]   out_room = RW'(16);
    logic            out_wr_en;
    logic [2*DW-1:0] out_data;

    always #5 clk = ~clk;

    lut_mult_sched_ctrl #(.DW(DW), .LAT(LAT), .CW(CW), .RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_count  (op_count),
        .busy      (busy),
        .done      (done),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .in_data   (in_data),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_valid (mul_valid),
        .mul_prod  (mul_prod),
        .out_room  (out_room),
        .out_wr_en (out_wr_en),
        .out_data  (out_data)
    );

    // Input FIFO: data appears on in_data the cycle after a pop.
    logic [15:0] fifo_mem [512];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        hold_empty = 1'b0;

    assign in_empty = (wr_ptr == rd_ptr) || hold_empty;

    always @(posedge clk) begin
        if (in_rd_en) begin
            in_data <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Multiplier: operands captured the edge after mul_valid, product LAT cycles after issue.
    logic [15:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_prod = mpipe[LAT-1];

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    vec_t        vecs [17];
    logic [4:0]  t1_ctl [8];
    logic [15:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop = 0, n_push = 0, n_done = 0, n_busy = 0, max_if = 0, cyc = 0;
    int push_cyc [512];

    logic       s_rd, s_mv, s_wr, s_busy, s_done;
    logic [7:0] s_mul_a, s_mul_b;
    logic [15:0] s_out_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Sample one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_rd = in_rd_en; s_mv = mul_valid; s_wr = out_wr_en; s_busy = busy; s_done = done;
        s_mul_a = mul_a; s_mul_b = mul_b; s_out_data = out_data;
        if (rst_n) begin
            if (in_rd_en) n_pop++;
            if (done)     n_done++;
            if (busy)     n_busy++;
            if (out_wr_en) begin
                push_cyc[n_push] = cyc;
                n_push++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_push: out_data=0x%0h with no product outstanding", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            if (n_pop - n_push > max_if) max_if = n_pop - n_push;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] s_pack();
        return {s_rd, s_mv, s_wr, s_busy, s_done};
    endfunction

    task automatic load(input int first, input int n, input bit track);
        for (int i = first; i < first + n; i++) begin
            fifo_mem[wr_ptr] = {vecs[i].a, vecs[i].b};
            wr_ptr++;
            if (track) exp_q.push_back(vecs[i].prod);
        end
    endtask

    task automatic pulse_start(input logic [CW-1:0] n);
        op_count = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (s_done) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        int p0, q0, d0, b0;

        vecs[0]  = {8'h05, 8'h03, 16'h000F};
        vecs[1]  = {8'hFD, 8'h07, 16'hFFEB};
        vecs[2]  = {8'h80, 8'h80, 16'h4000};
        vecs[3]  = {8'h7F, 8'hFF, 16'hFF81};
        vecs[4]  = {8'h02, 8'h03, 16'h0006};
        vecs[5]  = {8'hFF, 8'hFF, 16'h0001};
        vecs[6]  = {8'h0A, 8'hF6, 16'hFF9C};
        vecs[7]  = {8'h00, 8'h37, 16'h0000};
        vecs[8]  = {8'h80, 8'h7F, 16'hC080};
        vecs[9]  = {8'h7F, 8'h7F, 16'h3F01};
        vecs[10] = {8'h04, 8'h04, 16'h0010};
        vecs[11] = {8'hFE, 8'h09, 16'hFFEE};
        vecs[12] = {8'h64, 8'h03, 16'h012C};
        vecs[13] = {8'hF9, 8'hF9, 16'h0031};
        vecs[14] = {8'h01, 8'h01, 16'h0001};
        vecs[15] = {8'h02, 8'h02, 16'h0004};
        vecs[16] = {8'h03, 8'h03, 16'h0009};

        // {in_rd_en, mul_valid, out_wr_en, busy, done} per cycle after start for a single op.
        t1_ctl[0] = 5'b10010;
        t1_ctl[1] = 5'b01010;
        t1_ctl[2] = 5'b00010;
        t1_ctl[3] = 5'b00010;
        t1_ctl[4] = 5'b00010;
        t1_ctl[5] = 5'b00110;
        t1_ctl[6] = 5'b00001;
        t1_ctl[7] = 5'b00000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl_live", 32'({in_rd_en, mul_valid, out_wr_en, busy, done}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("reset_ctl_idle", 32'(s_pack()), 32'd0);

        // 1: single op 5*3, cycle-accurate control sequence
        load(0, 1, 1'b1);
        pulse_start(8'd1);
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("t1_ctl_c%0d", c), 32'(s_pack()), 32'(t1_ctl[c]));
            if (c == 1) check("t1_mul_ab", 32'({s_mul_a, s_mul_b}), 32'h0503);
            if (c == 5) check("t1_out_data", 32'(s_out_data), 32'h000F);
        end

        // 2: three signed extremes, back-to-back pushes
        p0 = n_pop; q0 = n_push; d0 = n_done;
        load(1, 3, 1'b1);
        pulse_start(8'd3);
        wait_done("t2_done_seen", 50);
        check("t2_pops", 32'(n_pop - p0), 32'd3);
        check("t2_pushes", 32'(n_push - q0), 32'd3);
        check("t2_back_to_back", 32'(push_cyc[q0+2] - push_cyc[q0]), 32'd2);
        check("t2_done_pulses", 32'(n_done - d0), 32'd1);
        check("t2_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 3: no credit stalls issue, then room held at 2 caps in-flight ops
        out_room = '0;
        p0 = n_pop; q0 = n_push;
        load(4, 6, 1'b1);
        pulse_start(8'd6);
        repeat (5) tick();
        check("t3_no_pop_at_room0", 32'(n_pop - p0), 32'd0);
        check("t3_busy_while_stalled", 32'(s_busy), 32'd1);
        max_if   = 0;
        out_room = RW'(2);
        wait_done("t3_done_seen", 200);
        check("t3_pops", 32'(n_pop - p0), 32'd6);
        check("t3_pushes", 32'(n_push - q0), 32'd6);
        check("t3_max_inflight", 32'(max_if), 32'd2);
        check("t3_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 4: in_empty toggling every cycle, a second start while busy is ignored
        out_room = RW'(16);
        p0 = n_pop; q0 = n_push; d0 = n_done;
        load(10, 4, 1'b1);
        hold_empty = 1'b1;
        pulse_start(8'd4);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 60; i++) begin
                hold_empty = ~hold_empty;
                start      = (i == 2);
                op_count   = (i == 2) ? 8'd7 : 8'd4;
                tick();
                if (s_done) begin
                    got = 1'b1;
                    break;
                end
            end
            start = 1'b0;
            check("t4_done_seen", 32'(got), 32'd1);
        end
        hold_empty = 1'b0;
        repeat (8) tick();
        check("t4_pops", 32'(n_pop - p0), 32'd4);
        check("t4_pushes", 32'(n_push - q0), 32'd4);
        check("t4_done_pulses", 32'(n_done - d0), 32'd1);
        check("t4_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 5: empty burst
        p0 = n_pop; b0 = n_busy; d0 = n_done;
        pulse_start(8'd0);
        tick();
        check("t5_done_next_cycle", 32'(s_done), 32'd1);
        check("t5_busy_low", 32'(s_busy), 32'd0);
        tick();
        check("t5_done_one_cycle", 32'(s_done), 32'd0);
        check("t5_no_pops", 32'(n_pop - p0), 32'd0);
        check("t5_busy_never", 32'(n_busy - b0), 32'd0);
        check("t5_done_pulses", 32'(n_done - d0), 32'd1);

        // 7: maximum burst length, a * -2
        p0 = n_pop; q0 = n_push; d0 = n_done;
        for (int i = 0; i < 255; i++) begin
            int av;
            av = (i >= 128) ? i - 256 : i;
            fifo_mem[wr_ptr] = {8'(i), 8'hFE};
            wr_ptr++;
            exp_q.push_back(16'(av * -2));
        end
        pulse_start(8'd255);
        wait_done("t7_done_seen", 600);
        check("t7_pops", 32'(n_pop - p0), 32'd255);
        check("t7_pushes", 32'(n_push - q0), 32'd255);
        check("t7_done_pulses", 32'(n_done - d0), 32'd1);
        check("t7_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset with three ops in flight abandons them
        p0 = n_pop;
        load(14, 3, 1'b0);
        pulse_start(8'd3);
        repeat (3) tick();
        check("t6_pops_before_reset", 32'(n_pop - p0), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t6_ctl_in_reset", 32'({in_rd_en, mul_valid, out_wr_en, busy, done}), 32'd0);
        tick();
        rst_n = 1'b1;
        q0 = n_push;
        repeat (12) tick();
        check("t6_no_push_after_reset", 32'(n_push - q0), 32'd0);
        check("t6_idle_after_reset", 32'(s_pack()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
